// File: rtl/button_processor.sv
// Multi-channel button front end: synchronizer, tick-based debouncer, press/release edges,
// long-press detection and optional per-channel auto-repeat.
module button_processor #(
    parameter int unsigned      WIDTH          = 4,
    parameter int unsigned      SAMPLE_CNT_MAX = 62500,
    parameter int unsigned      PULSE_CNT_MAX  = 200,
    parameter int unsigned      HOLD_TICKS     = 2500,
    parameter int unsigned      REPEAT_TICKS   = 500,
    parameter logic [WIDTH-1:0] REPEAT_EN      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_p,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_p
);

    localparam int unsigned SW   = $clog2(SAMPLE_CNT_MAX);
    localparam int unsigned PW   = $clog2(PULSE_CNT_MAX + 1);
    localparam int unsigned HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [PW-1:0] PULSE_MAX   = PW'(PULSE_CNT_MAX);
    localparam logic [PW-1:0] P_ONE       = PW'(1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REP_LAST    = HW'(REPEAT_TICKS - 1);
    localparam logic [HW-1:0] H_ONE       = HW'(1);

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [SW-1:0]    r_scnt;
    logic             w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_scnt  <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_scnt  <= w_tick ? '0 : r_scnt + S_ONE;
        end
    end

    assign w_tick = (r_scnt == SAMPLE_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [PW-1:0] r_pcnt;
        logic [HW-1:0] r_hcnt;
        state_e        r_state;
        logic          r_lvl;
        logic          r_lvl_d;
        logic          r_press;
        logic          r_rel;
        logic          r_long;
        logic          r_rep;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pcnt  <= '0;
                r_hcnt  <= '0;
                r_state <= StIdle;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
            end else begin
                if (!r_sync2[i]) begin
                    r_pcnt <= '0;
                end else if (w_tick && (r_pcnt != PULSE_MAX)) begin
                    r_pcnt <= r_pcnt + P_ONE;
                end
                r_lvl   <= (r_pcnt == PULSE_MAX);
                r_lvl_d <= r_lvl;
                r_press <= r_lvl & ~r_lvl_d;
                r_rel   <= ~r_lvl & r_lvl_d;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
                // A release always wins over a terminal count in the same cycle.
                if (!r_lvl) begin
                    r_state <= StIdle;
                    r_hcnt  <= '0;
                end else begin
                    case (r_state)
                        StIdle: begin
                            r_state <= StPressed;
                            r_hcnt  <= '0;
                        end
                        StPressed: begin
                            if (w_tick) begin
                                if (r_hcnt == HOLD_LAST) begin
                                    r_long  <= 1'b1;
                                    r_hcnt  <= '0;
                                    r_state <= StHeld;
                                end else begin
                                    r_hcnt <= r_hcnt + H_ONE;
                                end
                            end
                        end
                        StHeld: begin
                            if (w_tick && REPEAT_EN[i]) begin
                                if (r_hcnt == REP_LAST) begin
                                    r_rep  <= 1'b1;
                                    r_hcnt <= '0;
                                end else begin
                                    r_hcnt <= r_hcnt + H_ONE;
                                end
                            end
                        end
                        default: begin
                            r_state <= StIdle;
                            r_hcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[i]      = r_lvl;
        assign press[i]      = r_press;
        assign release_p[i]  = r_rel;
        assign long_press[i] = r_long;
        assign repeat_p[i]   = r_rep;
    end

endmodule

// File: tb/tb_button_processor.sv
// Randomized and directed bench for button_processor against a tick-counting behavioural model.
module tb_button_processor;

    localparam int unsigned W   = 2;
    localparam int unsigned SCM = 4;
    localparam int unsigned PCM = 3;
    localparam int unsigned HT  = 5;
    localparam int unsigned RT  = 2;
    localparam logic [1:0]  REN = 2'b10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] in    = 2'b00;
    logic [1:0] level, press, release_p, long_press, repeat_p;

    button_processor #(
        .WIDTH         (W),
        .SAMPLE_CNT_MAX(SCM),
        .PULSE_CNT_MAX (PCM),
        .HOLD_TICKS    (HT),
        .REPEAT_TICKS  (RT),
        .REPEAT_EN     (REN)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .level     (level),
        .press     (press),
        .release_p (release_p),
        .long_press(long_press),
        .repeat_p  (repeat_p)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: total ticks since the debounced level rose decide long/repeat pulses.
    logic [1:0] ren_v = REN;
    int         m_scnt = 0;
    bit         m_tick;
    logic [1:0] m_s1 = 0, m_s2 = 0;
    int         m_cnt [2] = '{0, 0};
    bit         m_act [2] = '{0, 0};
    int         m_ticks [2] = '{0, 0};
    logic [1:0] m_lvl = 0, m_lvl_d = 0, m_press = 0, m_rel = 0, m_long = 0, m_rep = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scnt = 0;
            m_s1 = 0; m_s2 = 0;
            m_lvl = 0; m_lvl_d = 0; m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_act[i] = 0; m_ticks[i] = 0;
            end
        end else begin
            m_tick = (m_scnt == SCM - 1);
            m_scnt = (m_scnt + 1) % SCM;
            for (int i = 0; i < 2; i++) begin
                m_press[i] = m_lvl[i] & ~m_lvl_d[i];
                m_rel[i]   = ~m_lvl[i] & m_lvl_d[i];
                m_long[i]  = 1'b0;
                m_rep[i]   = 1'b0;
                if (!m_lvl[i]) begin
                    m_act[i] = 0; m_ticks[i] = 0;
                end else if (!m_act[i]) begin
                    m_act[i] = 1; m_ticks[i] = 0;
                end else if (m_tick) begin
                    m_ticks[i]++;
                    m_long[i] = (m_ticks[i] == HT);
                    m_rep[i]  = ren_v[i] && (m_ticks[i] > HT) && ((m_ticks[i] - HT) % RT == 0);
                end
                m_lvl_d[i] = m_lvl[i];
                m_lvl[i]   = (m_cnt[i] == PCM);
                if (!m_s2[i]) m_cnt[i] = 0;
                else if (m_tick && m_cnt[i] < PCM) m_cnt[i]++;
            end
            m_s2 = m_s1;
            m_s1 = in;
        end
    end

    bit chk_en = 0;
    int c_press [2], c_rel [2], c_long [2], c_rep [2];

    always @(negedge clk) begin
        if (chk_en) begin
            check("model", {level, press, release_p, long_press, repeat_p},
                  {m_lvl, m_press, m_rel, m_long, m_rep});
            for (int i = 0; i < 2; i++) begin
                c_press[i] += int'(press[i]);
                c_rel[i]   += int'(release_p[i]);
                c_long[i]  += int'(long_press[i]);
                c_rep[i]   += int'(repeat_p[i]);
            end
        end
    end

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; c_rep[i] = 0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lat, k_lvl, k_long, k_rep, rel_seen, rep_after;
    logic [1:0] pv;

    initial begin
        clr_counts();
        // Reset held with buttons pressed.
        #1 rst_n = 1'b0;
        in = 2'b11;
        chk_en = 1;
        step(6);
        check("rst_outs", {level, press, release_p, long_press, repeat_p}, 0);
        rst_n = 1'b1;
        in = 2'b00;
        clr_counts();
        step(100);
        check("idle_pulses", c_press[0] + c_press[1] + c_rel[0] + c_rel[1] + c_long[0]
              + c_long[1] + c_rep[0] + c_rep[1], 0);

        // Bounce faster than the debounce window, then hold.
        clr_counts();
        for (int k = 0; k < 20; k++) begin
            in[0] = ~in[0];
            step(3);
        end
        check("bounce_nopress", c_press[0], 0);
        in[0] = 1'b1;
        step(40);
        check("bounce_press", c_press[0], 1);
        check("bounce_level", {31'd0, level[0]}, 1);
        in[0] = 1'b0;
        step(40);

        // Short press.
        clr_counts();
        in[0] = 1'b1;
        step(20);
        in[0] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (release_p[0] && lat < 0) lat = k - 1;
        end
        @(posedge clk); #1;
        check("short_rel_lat", lat, 5);
        check("short_press", c_press[0], 1);
        check("short_rel", c_rel[0], 1);
        check("short_nolong", c_long[0], 0);
        step(20);

        // Long press on the non-repeating channel.
        clr_counts();
        in[0] = 1'b1;
        k_lvl = -1000; k_long = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (level[0] && k_lvl < 0) k_lvl = k;
            if (long_press[0] && k_long == 0) k_long = k;
        end
        @(posedge clk); #1;
        in[0] = 1'b0;
        step(30);
        check("long_press_cnt", c_press[0], 1);
        check("long_long_cnt", c_long[0], 1);
        check("long_norepeat", c_rep[0], 0);
        check("long_delay", k_long - k_lvl, HT * SCM - 1);

        // Long press with auto-repeat.
        clr_counts();
        in[1] = 1'b1;
        k_long = 0; k_rep = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (long_press[1] && k_long == 0) k_long = k;
            if (repeat_p[1] && k_rep == 0) k_rep = k;
        end
        @(posedge clk); #1;
        in[1] = 1'b0;
        rel_seen = 0; rep_after = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rel_seen != 0 && repeat_p[1]) rep_after++;
            if (release_p[1]) rel_seen++;
        end
        @(posedge clk); #1;
        check("rep_long_cnt", c_long[1], 1);
        check("rep_interval", k_rep - k_long, RT * SCM);
        check("rep_release", rel_seen, 1);
        check("rep_after_rel", rep_after, 0);
        step(10);

        // Both channels together, then reset mid-hold.
        clr_counts();
        in = 2'b11;
        pv = 2'b00;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (press != 2'b00 && pv == 2'b00) pv = press;
        end
        check("conc_press", {30'd0, pv}, 2'b11);
        @(posedge clk);
        #3 rst_n = 1'b0;
        in = 2'b00;
        #1 check("rst_mid_outs", {level, press, release_p, long_press, repeat_p}, 0);
        step(3);
        rst_n = 1'b1;
        clr_counts();
        step(30);
        check("rst_no_release", c_rel[0] + c_rel[1] + c_press[0] + c_press[1], 0);

        // Random segments checked against the model.
        for (int s = 0; s < 60; s++) begin
            in = 2'($urandom_range(0, 3));
            step($urandom_range(1, 40));
        end
        in = 2'b00;
        step(20);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
